verify_message_stream: RTL and testbench

- Parametrised, clocked successor of the receiver-side message verifier in the authenticator path.
- Accepts one framed message per valid/ready handshake, along with the expected tag from the upstream MAC engine and the current local time.
- Checks the tag, checks the freshness window, and optionally checks replay (strictly increasing timestamps).
- Emits the payload with a status code through a held output handshake, and keeps saturating accept/reject counters.

---
 rtl/verify_pkg.sv | 33 +++
 rtl/verify_message_stream_ts_window_check.sv | 26 ++
 rtl/verify_message_stream.sv | 143 ++++++++++++++
 tb/tb_verify_message_stream.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/verify_pkg.sv
// Shared types and field-layout helpers for the receiver-side message verifier.
package verify_pkg;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_TAG_FAIL = 3'd1,
    ST_STALE    = 3'd2,
    ST_FUTURE   = 3'd3,
    ST_REPLAY   = 3'd4
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  function automatic int unsigned payload_w(input int unsigned msg_w, input int unsigned tag_w);
    return msg_w - tag_w;
  endfunction

  // Timestamp occupies the top TS_W bits of the frame.
  function automatic int unsigned ts_lsb(input int unsigned msg_w, input int unsigned ts_w);
    return msg_w - ts_w;
  endfunction

  localparam int unsigned DEF_MSG_W     = 512;
  localparam int unsigned DEF_TAG_W     = 40;
  localparam int unsigned DEF_TS_W      = 32;
  localparam int unsigned DEF_PAYLOAD_W = payload_w(DEF_MSG_W, DEF_TAG_W);
  localparam int unsigned DEF_TS_LSB    = ts_lsb(DEF_MSG_W, DEF_TS_W);

endpackage

// File: rtl/verify_message_stream_ts_window_check.sv
// Freshness window compare; one extra bit of headroom so neither edge wraps.
module ts_window_check #(
  parameter int unsigned TS_W  = 32,
  parameter int unsigned THR_W = 10
) (
  input  logic [TS_W-1:0]  ts,
  input  logic [TS_W-1:0]  now,
  input  logic [THR_W-1:0] thr,
  output logic             stale,
  output logic             future
);

  localparam int unsigned XW = TS_W + 1;

  logic [XW-1:0] ts_x;
  logic [XW-1:0] now_x;
  logic [XW-1:0] thr_x;

  assign ts_x  = {1'b0, ts};
  assign now_x = {1'b0, now};
  assign thr_x = XW'(thr);

  assign stale  = (ts_x + thr_x) < now_x;
  assign future = ts_x > (now_x + thr_x);

endmodule

// File: rtl/verify_message_stream.sv
// Receiver-side message verifier: tag, freshness and replay checks with a held result handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | in_ready high, waiting for a frame to capture
// S_CHECK | captured frame evaluated; result, history, counters update
// S_HOLD  | out_valid high with outputs frozen until out_ready
module verify_message_stream
  import verify_pkg::*;
#(
  parameter int unsigned MSG_W     = 512,
  parameter int unsigned TAG_W     = 40,
  parameter int unsigned TS_W      = 32,
  parameter int unsigned THR_W     = 10,
  parameter int unsigned CNT_W     = 16,
  parameter bit          REPLAY_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MSG_W-1:0]       in_frame,
  input  logic [TAG_W-1:0]       in_exp_tag,
  input  logic [TS_W-1:0]        now_ts,
  input  logic [THR_W-1:0]       threshold,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MSG_W-TAG_W-1:0] out_payload,
  output logic [2:0]             out_status,
  output logic                   out_ok,
  output logic [CNT_W-1:0]       ok_cnt,
  output logic [CNT_W-1:0]       err_cnt
);

  localparam int unsigned PAY_W  = payload_w(MSG_W, TAG_W);
  localparam int unsigned TS_LSB = ts_lsb(MSG_W, TS_W);

  state_e            state;
  logic [MSG_W-1:0]  cap_frame;
  logic [TAG_W-1:0]  cap_tag;
  logic [TS_W-1:0]   cap_now;
  logic [THR_W-1:0]  cap_thr;
  logic              have_last;
  logic [TS_W-1:0]   last_ts;

  logic [TS_W-1:0]   cap_ts;
  logic [PAY_W-1:0]  cap_payload;
  logic              tag_fail;
  logic              stale;
  logic              future;
  logic              replay;
  status_e           status_nxt;

  assign cap_ts      = cap_frame[TS_LSB +: TS_W];
  assign cap_payload = cap_frame[MSG_W-1:TAG_W];
  assign tag_fail    = cap_frame[TAG_W-1:0] != cap_tag;
  assign replay      = REPLAY_EN && have_last && (cap_ts <= last_ts);

  ts_window_check #(
    .TS_W  (TS_W),
    .THR_W (THR_W)
  ) u_window (
    .ts     (cap_ts),
    .now    (cap_now),
    .thr    (cap_thr),
    .stale  (stale),
    .future (future)
  );

  always_comb begin
    status_nxt = ST_OK;
    if (tag_fail)    status_nxt = ST_TAG_FAIL;
    else if (stale)  status_nxt = ST_STALE;
    else if (future) status_nxt = ST_FUTURE;
    else if (replay) status_nxt = ST_REPLAY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_payload <= '0;
      out_status  <= ST_OK;
      out_ok      <= 1'b0;
      cap_frame   <= '0;
      cap_tag     <= '0;
      cap_now     <= '0;
      cap_thr     <= '0;
      have_last   <= 1'b0;
      last_ts     <= '0;
      ok_cnt      <= '0;
      err_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            cap_frame <= in_frame;
            cap_tag   <= in_exp_tag;
            cap_now   <= now_ts;
            cap_thr   <= threshold;
            in_ready  <= 1'b0;
            state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          out_valid  <= 1'b1;
          out_status <= status_nxt;
          if (status_nxt == ST_OK) begin
            out_ok      <= 1'b1;
            out_payload <= cap_payload;
            last_ts     <= cap_ts;
            have_last   <= 1'b1;
            if (ok_cnt != '1) ok_cnt <= ok_cnt + CNT_W'(1);
          end else begin
            out_ok      <= 1'b0;
            out_payload <= '0;
            if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
          end
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Flush overrides any history/counter update made by CHECK this cycle.
      if (flush) begin
        have_last <= 1'b0;
        last_ts   <= '0;
        ok_cnt    <= '0;
        err_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_verify_message_stream.sv
// Bench for verify_message_stream: two instances (replay on/off) against a behavioural model.
module tb_verify_message_stream;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic [511:0] in_frame;
  logic [39:0]  in_exp_tag;
  logic [31:0]  now_ts;
  logic [9:0]   threshold;
  logic         out_ready;

  logic         a_in_ready, b_in_ready;
  logic         a_out_valid, b_out_valid;
  logic [471:0] a_out_payload, b_out_payload;
  logic [2:0]   a_out_status, b_out_status;
  logic         a_out_ok, b_out_ok;
  logic [15:0]  a_ok_cnt, b_ok_cnt, a_err_cnt, b_err_cnt;

  always #5 clk = ~clk;

  verify_message_stream #(.REPLAY_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_frame(in_frame), .in_exp_tag(in_exp_tag), .now_ts(now_ts), .threshold(threshold),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_payload(a_out_payload),
    .out_status(a_out_status), .out_ok(a_out_ok), .ok_cnt(a_ok_cnt), .err_cnt(a_err_cnt)
  );

  verify_message_stream #(.REPLAY_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_frame(in_frame), .in_exp_tag(in_exp_tag), .now_ts(now_ts), .threshold(threshold),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_payload(b_out_payload),
    .out_status(b_out_status), .out_ok(b_out_ok), .ok_cnt(b_ok_cnt), .err_cnt(b_err_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state per instance: index 0 has replay checking, index 1 does not.
  bit           m_have[2];
  logic [31:0]  m_last[2];
  int           m_ok[2];
  int           m_err[2];
  logic [2:0]   e_st[2];
  logic [471:0] e_pay[2];

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [2:0] model_status(input logic [31:0] t, input logic [31:0] n,
                                              input logic [9:0] h, input bit tag_ok,
                                              input bit have, input logic [31:0] last, input bit en);
    longint lt = t;
    longint ln = n;
    longint lh = h;
    if (!tag_ok)                 return 3'd1;
    if (lt + lh < ln)            return 3'd2;
    if (lt > ln + lh)            return 3'd3;
    if (en && have && t <= last) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [511:0] rand_frame();
    logic [511:0] f;
    for (int w = 0; w < 16; w++) f[w*32 +: 32] = $urandom;
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_have[i] = 1'b0; m_last[i] = '0; m_ok[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic check_inst(input string p, input logic ov, input logic [2:0] st, input logic ok,
                            input logic [471:0] pay, input logic [15:0] okc, input logic [15:0] errc,
                            input int i);
    chk({p, "_out_valid"}, ov, 1'b1);
    chk({p, "_status"}, st, e_st[i]);
    chk({p, "_out_ok"}, ok, e_st[i] == 3'd0);
    chk({p, "_payload"}, pay, e_pay[i]);
    chk({p, "_ok_cnt"}, okc, 16'(m_ok[i]));
    chk({p, "_err_cnt"}, errc, 16'(m_err[i]));
  endtask

  task automatic check_both(input string p);
    check_inst({p, "_a"}, a_out_valid, a_out_status, a_out_ok, a_out_payload, a_ok_cnt, a_err_cnt, 0);
    check_inst({p, "_b"}, b_out_valid, b_out_status, b_out_ok, b_out_payload, b_ok_cnt, b_err_cnt, 1);
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!(a_in_ready && b_in_ready) && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("idle_in_ready", {a_in_ready, b_in_ready}, 2'b11);
  endtask

  task automatic run_frame(input logic [31:0] t, input logic [31:0] n, input logic [9:0] h,
                           input bit bad_tag, input int stall, input bit flush_chk);
    logic [511:0] f;
    logic [39:0]  et;
    logic [2:0]   s;
    f = rand_frame();
    f[511 -: 32] = t;
    et = f[39:0];
    if (bad_tag) et[$urandom_range(0, 39)] ^= 1'b1;
    wait_ready();
    in_valid = 1'b1; in_frame = f; in_exp_tag = et; now_ts = n; threshold = h;
    @(negedge clk);
    // Scramble the sampled inputs to confirm they were captured, not used live.
    in_valid = 1'b0; now_ts = $urandom; threshold = 10'($urandom);
    in_exp_tag = 40'({$urandom, $urandom});
    chk("check_out_valid", {a_out_valid, b_out_valid}, 2'b00);
    chk("check_in_ready", {a_in_ready, b_in_ready}, 2'b00);
    flush = flush_chk;
    for (int i = 0; i < 2; i++) begin
      s = model_status(t, n, h, !bad_tag, m_have[i], m_last[i], i == 0);
      e_st[i]  = s;
      e_pay[i] = (s == 3'd0) ? f[511:40] : '0;
      if (flush_chk) begin
        m_have[i] = 1'b0; m_last[i] = '0; m_ok[i] = 0; m_err[i] = 0;
      end else if (s == 3'd0) begin
        m_have[i] = 1'b1; m_last[i] = t;
        if (m_ok[i] != 65535) m_ok[i]++;
      end else if (m_err[i] != 65535) m_err[i]++;
    end
    @(negedge clk);
    flush = 1'b0;
    check_both("hold");
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      in_frame = rand_frame();
      now_ts = $urandom;
      @(negedge clk);
      check_both("stall");
      chk("stall_in_ready", {a_in_ready, b_in_ready}, 2'b00);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("exit_out_valid", {a_out_valid, b_out_valid}, 2'b00);
    chk("exit_in_ready", {a_in_ready, b_in_ready}, 2'b11);
  endtask

  task automatic flush_idle();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    chk("flush_cnts", {a_ok_cnt, a_err_cnt, b_ok_cnt, b_err_cnt}, 64'd0);
  endtask

  task automatic reset_mid();
    wait_ready();
    in_valid = 1'b1; in_frame = rand_frame(); in_exp_tag = in_frame[39:0];
    now_ts = in_frame[511 -: 32]; threshold = 10'd5;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_mid_a", {a_in_ready, a_out_valid, a_out_payload, a_out_status, a_out_ok, a_ok_cnt, a_err_cnt}, '0);
    chk("rst_mid_b", {b_in_ready, b_out_valid, b_ok_cnt, b_err_cnt}, '0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_mid_no_out", {a_out_valid, b_out_valid}, 2'b00);
    end
  endtask

  initial begin
    logic [31:0] n, t;
    logic [9:0]  h;
    int          d;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_frame = '0; in_exp_tag = '0;
    now_ts = '0; threshold = '0; out_ready = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", a_in_ready, 1'b0);
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_payload", a_out_payload, '0);
    chk("rst_status", a_out_status, 3'd0);
    chk("rst_out_ok", a_out_ok, 1'b0);
    chk("rst_cnts", {a_ok_cnt, a_err_cnt, b_ok_cnt, b_err_cnt}, 64'd0);
    reset = 1'b0;

    run_frame(32'd1000, 32'd1005, 10'd10, 1'b0, 0, 1'b0);
    run_frame(32'd1001, 32'd1005, 10'd10, 1'b1, 0, 1'b0);
    flush_idle();
    run_frame(32'd990,  32'd1000, 10'd10, 1'b0, 0, 1'b0);
    run_frame(32'd989,  32'd1000, 10'd10, 1'b0, 0, 1'b0);
    run_frame(32'd1011, 32'd1000, 10'd10, 1'b0, 0, 1'b0);
    flush_idle();
    run_frame(32'd0, 32'd5, 10'd10, 1'b0, 0, 1'b0);
    run_frame(32'hFFFFFFFF, 32'hFFFFFFFA, 10'd10, 1'b0, 0, 1'b0);
    flush_idle();
    run_frame(32'd500, 32'd500, 10'd0, 1'b0, 0, 1'b0);
    run_frame(32'd502, 32'd501, 10'd0, 1'b0, 0, 1'b0);
    run_frame(32'd500, 32'd501, 10'd0, 1'b0, 0, 1'b0);
    flush_idle();
    run_frame(32'd2000, 32'd2000, 10'd10, 1'b0, 0, 1'b0);
    run_frame(32'd2000, 32'd2000, 10'd10, 1'b0, 0, 1'b0);
    run_frame(32'd2001, 32'd2000, 10'd10, 1'b0, 5, 1'b0);
    run_frame(32'd2005, 32'd2000, 10'd10, 1'b0, 0, 1'b1);
    run_frame(32'd2005, 32'd2000, 10'd10, 1'b0, 0, 1'b0);
    reset_mid();
    run_frame(32'd3000, 32'd3000, 10'd3, 1'b0, 0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      n = $urandom;
      h = 10'($urandom_range(0, 1023));
      d = int'($urandom_range(0, 2 * int'(h) + 6)) - (int'(h) + 3);
      t = n + 32'(d);
      if ($urandom_range(0, 5) == 0) begin
        t = m_last[0];
        n = t;
      end
      run_frame(t, n, h, $urandom_range(0, 4) == 0, int'($urandom_range(0, 3)),
                $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
